stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Push/pop stack controller that sits directly upstream of the single-port RAM and owns its data, address, write-enable and byte-enable inputs. It turns push/pop requests from a client into RAM write and read cycles, keeps the stack pointer, reports full/empty, and returns popped words once the RAM's registered read data arrives.

## Interface
Parameters:
- DATA_W, 16, word width; matches RAM data width
- ADDR_W, 8, RAM address width
- DEPTH, 256, stack capacity in words, 1..2^ADDR_W
- BASE_ADDR, 0, RAM address of stack slot 0; BASE_ADDR+DEPTH-1 must not exceed 2^ADDR_W-1

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- push  in  1  push request, sampled when ready=1
- pop  in  1  pop request, sampled when ready=1
- push_data  in  DATA_W  word to push
- push_byteena  in  1  byte-enable forwarded to RAM with the push write
- ready  out  1  controller idle; request accepted this cycle
- pop_data  out  DATA_W  popped word, valid while pop_valid=1
- pop_valid  out  1  one-cycle pulse, pop_data valid
- full  out  1  count==DEPTH
- empty  out  1  count==0
- count  out  ADDR_W+1  words on stack
- op_err  out  1  one-cycle pulse: rejected request
- ram_data  out  DATA_W  to RAM data_in
- ram_addr  out  ADDR_W  to RAM addr
- ram_we  out  1  to RAM we
- ram_byteena  out  1  to RAM byteena
- ram_q  in  DATA_W  from RAM data_out, valid one clock after the address is presented

## Operation
- State machine states: IDLE, WR, RD_ADDR, RD_WAIT, RD_OUT. ready=1 only in IDLE.
- Stack pointer sp ranges 0..DEPTH and equals count. It points at the next free slot.
- IDLE handling of requests:
  - push=1, pop=0, not full: latch push_data and push_byteena, go to WR.
  - pop=1, push=0, not empty: go to RD_ADDR.
  - push=1 and full, pop=1 and empty, or push=1 and pop=1 together: reject. Pulse op_err for one cycle, stay in IDLE, and leave sp and the RAM untouched.
- WR: ram_we=1, ram_addr=BASE_ADDR+sp, ram_data and ram_byteena from the latches. sp increments at the end of the cycle. Next state IDLE.
- RD_ADDR: ram_we=0, ram_addr=BASE_ADDR+sp-1. sp decrements at the end of the cycle. Next state RD_WAIT.
- RD_WAIT: ram_addr holds its value and ram_we=0. Next state RD_OUT.
- RD_OUT: ram_q is registered into pop_data, and pop_valid pulses in the following cycle, which is back in IDLE. pop_data holds its value until the next pop.
- Outside WR, ram_we=0 always. ram_byteena=1 whenever ram_we=0.
- full and empty are decoded combinationally from sp. count=sp.
- Address arithmetic is ADDR_W bits wide. By construction it never wraps, so no wrap-around case exists.

## Timing
- Reset (asynchronous, rst_n=0) forces:
  - state IDLE, sp=0
  - ready=1, empty=1, full=0, count=0
  - pop_valid=0, op_err=0, pop_data=0
  - ram_we=0, ram_addr=BASE_ADDR, ram_data=0, ram_byteena=1
- Reset asserted mid-operation aborts it immediately. A WR cut short by reset may or may not have written the RAM; sp is 0 either way.
- Push accepted at edge N:
  - RAM write happens at edge N+1.
  - count updates after edge N+1.
  - ready=1 again after edge N+1.
  - Throughput is one push per 2 cycles.
- Pop accepted at edge N:
  - address presented during cycle N..N+1
  - ram_q valid during cycle N+2..N+3
  - pop_valid=1 during cycle N+3..N+4
  - ready=1 again after edge N+3
  - Latency is 4 cycles.
- count decrements after edge N+1, so a full stack shows full=0 one cycle after a pop is accepted.
- op_err is registered: it is high during the cycle after the rejected request edge.

## Test plan
- Reset, then push 16'h2000, 16'h4000, 16'h6000 -> RAM written at addresses 0, 1, 2, count=3, empty=0, no op_err.
- Pop three times after that sequence -> pop_data = 16'h6000, 16'h4000, 16'h2000, each pop_valid exactly 4 cycles after acceptance, count=0, empty=1.
- Pop on an empty stack -> op_err one-cycle pulse, no RAM access, count stays 0. With DEPTH=4, a 5th push -> op_err pulse, full=1, count=4, address 4 never written.
- push=1 and pop=1 in the same cycle with count=2 -> op_err pulse, count=2, ram_we never asserted.
- Push with push_byteena=0 -> ram_byteena=0 exactly during the WR cycle, 1 otherwise. BASE_ADDR=8'h10 -> first push goes to address 8'h10.
- Drop rst_n during RD_WAIT -> all outputs take their reset values without waiting for a clock, no pop_valid afterwards, and a subsequent push goes to BASE_ADDR.

Source files
------------

// File: rtl/stack_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stack_ctrl : push/pop stack controller in front of a single-port RAM |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module stack_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_byteena,
    output logic              ready,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              op_err,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_byteena,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [ADDR_W-1:0] c_base    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_depth   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_sp_one  = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RD_OUT  = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W:0]     r_sp;
    logic [DATA_W-1:0]   r_pop_data;
    logic                r_pop_valid;
    logic                r_op_err;
    logic [DATA_W-1:0]   r_ram_data;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_ram_we;
    logic                r_ram_byteena;

    logic                w_full;
    logic                w_empty;
    logic                w_push_ok;
    logic                w_pop_ok;
    logic                w_reject;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [ADDR_W-1:0]   w_rd_addr;

    assign w_full    = (r_sp == c_depth);
    assign w_empty   = (r_sp == '0);
    assign w_push_ok = push & ~pop & ~w_full;
    assign w_pop_ok  = pop & ~push & ~w_empty;
    assign w_reject  = (push | pop) & ~w_push_ok & ~w_pop_ok;

    // sp is the next free slot; the top-of-stack word lives one below it
    assign w_wr_addr = c_base + r_sp[ADDR_W-1:0];
    assign w_rd_addr = w_wr_addr - c_addr_one;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_sp          <= '0;
            r_pop_data    <= '0;
            r_pop_valid   <= 1'b0;
            r_op_err      <= 1'b0;
            r_ram_data    <= '0;
            r_ram_addr    <= c_base;
            r_ram_we      <= 1'b0;
            r_ram_byteena <= 1'b1;
        end else begin
            r_op_err    <= 1'b0;
            r_pop_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_push_ok) begin
                        r_state       <= S_WR;
                        r_ram_we      <= 1'b1;
                        r_ram_addr    <= w_wr_addr;
                        r_ram_data    <= push_data;
                        r_ram_byteena <= push_byteena;
                    end else if (w_pop_ok) begin
                        r_state    <= S_RD_ADDR;
                        r_ram_addr <= w_rd_addr;
                    end else if (w_reject) begin
                        r_op_err <= 1'b1;
                    end
                end
                S_WR: begin
                    r_state       <= S_IDLE;
                    r_ram_we      <= 1'b0;
                    r_ram_byteena <= 1'b1;
                    r_sp          <= r_sp + c_sp_one;
                end
                S_RD_ADDR: begin
                    r_state <= S_RD_WAIT;
                    r_sp    <= r_sp - c_sp_one;
                end
                S_RD_WAIT: begin
                    r_state <= S_RD_OUT;
                end
                S_RD_OUT: begin
                    r_state     <= S_IDLE;
                    r_pop_data  <= ram_q;
                    r_pop_valid <= 1'b1;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_ram_we      <= 1'b0;
                    r_ram_byteena <= 1'b1;
                end
            endcase
        end
    end

    assign ready       = (r_state == S_IDLE);
    assign full        = w_full;
    assign empty       = w_empty;
    assign count       = r_sp;
    assign pop_data    = r_pop_data;
    assign pop_valid   = r_pop_valid;
    assign op_err      = r_op_err;
    assign ram_data    = r_ram_data;
    assign ram_addr    = r_ram_addr;
    assign ram_we      = r_ram_we;
    assign ram_byteena = r_ram_byteena;

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_stack_ctrl : vector table + scoreboard bench for stack_ctrl       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_stack_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int BASE   = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic [DATA_W-1:0] push_data = '0;
    logic              push_byteena = 1'b1;
    logic              ready;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              op_err;
    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic              ram_byteena;
    logic [DATA_W-1:0] ram_q;

    stack_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
        .push_data(push_data), .push_byteena(push_byteena),
        .ready(ready), .pop_data(pop_data), .pop_valid(pop_valid),
        .full(full), .empty(empty), .count(count), .op_err(op_err),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_byteena(ram_byteena), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // single-port RAM with registered read; byteena gates the write
    logic [DATA_W-1:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_we && ram_byteena) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        logic        be;
        int          at;
    } wr_t;
    typedef struct {
        logic [15:0] data;
        int          at;
    } rd_t;

    wr_t wr_q[$];
    rd_t rd_q[$];

    logic [15:0] model_ram [0:255];
    int          model_sp = 0;
    initial for (int i = 0; i < 256; i++) model_ram[i] = '0;

    // scoreboard side: every RAM write and every pop_valid must match an expectation
    always @(negedge clk) begin : mon
        wr_t w;
        rd_t r;
        if (rst_n) begin
            if (ram_we) begin
                if (wr_q.size() == 0) chk("unexpected_write", 32'(1), 32'(0));
                else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", 32'(ram_addr), 32'(w.addr));
                    chk("wr_data", 32'(ram_data), 32'(w.data));
                    chk("wr_byteena", 32'(ram_byteena), 32'(w.be));
                    chk("wr_cycle", 32'(cyc), 32'(w.at));
                end
            end else begin
                chk("idle_byteena", 32'(ram_byteena), 32'(1));
            end
            if (pop_valid) begin
                if (rd_q.size() == 0) chk("unexpected_pop_valid", 32'(1), 32'(0));
                else begin
                    r = rd_q.pop_front();
                    chk("pop_data", 32'(pop_data), 32'(r.data));
                    chk("pop_cycle", 32'(cyc), 32'(r.at));
                end
            end
        end
    end

    typedef struct {
        logic        push;
        logic        pop;
        logic [15:0] data;
        logic        be;
        logic        exp_err;
        int          exp_count;
        logic        exp_full;
        logic        exp_empty;
    } vec_t;

    vec_t vecs [16];

    task automatic check_reset();
        chk("rst_ready", 32'(ready), 32'(1));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_pop_valid", 32'(pop_valid), 32'(0));
        chk("rst_op_err", 32'(op_err), 32'(0));
        chk("rst_pop_data", 32'(pop_data), 32'(0));
        chk("rst_ram_we", 32'(ram_we), 32'(0));
        chk("rst_ram_addr", 32'(ram_addr), 32'(BASE));
        chk("rst_ram_data", 32'(ram_data), 32'(0));
        chk("rst_ram_byteena", 32'(ram_byteena), 32'(1));
    endtask

    task automatic apply(input vec_t v);
        int   old_cnt;
        int   guard;
        logic acc;
        wr_t  w;
        rd_t  r;
        @(negedge clk);
        old_cnt = model_sp;
        acc = !v.exp_err;
        push = v.push;
        pop = v.pop;
        push_data = v.data;
        push_byteena = v.be;
        if (acc && v.push) begin
            w.addr = 8'(BASE + model_sp);
            w.data = v.data;
            w.be = v.be;
            w.at = cyc + 1;
            wr_q.push_back(w);
            if (v.be) model_ram[BASE + model_sp] = v.data;
            model_sp++;
        end
        if (acc && v.pop) begin
            model_sp--;
            r.data = model_ram[BASE + model_sp];
            r.at = cyc + 4;
            rd_q.push_back(r);
        end
        @(posedge clk);
        @(negedge clk);
        push = 1'b0;
        pop = 1'b0;
        chk("op_err", 32'(op_err), 32'(v.exp_err));
        chk("ready_after_req", 32'(ready), 32'(!acc));
        chk("count_lag", 32'(count), 32'(old_cnt));
        @(negedge clk);
        chk("op_err_pulse", 32'(op_err), 32'(0));
        chk("count", 32'(count), 32'(v.exp_count));
        chk("full", 32'(full), 32'(v.exp_full));
        chk("empty", 32'(empty), 32'(v.exp_empty));
        guard = 0;
        while (!ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_timeout", 32'(guard < 20), 32'(1));
        #1;
        chk("wr_pending", 32'(wr_q.size()), 32'(0));
        chk("rd_pending", 32'(rd_q.size()), 32'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        vec_t v;
        //           push  pop   data     be    err   cnt full  empty
        vecs[0]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 16'h2000, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h4000, 1'b1, 1'b0, 2, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'h6000, 1'b1, 1'b0, 3, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 2, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 16'h1111, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 16'h2222, 1'b1, 1'b0, 2, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 16'h9999, 1'b1, 1'b1, 2, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 16'h3333, 1'b0, 1'b0, 3, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 16'h4444, 1'b1, 1'b0, 4, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 16'h5555, 1'b1, 1'b1, 4, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 3, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 2, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1, 1'b0, 1'b0};

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) apply(vecs[i]);

        // abort a pop in RD_WAIT with an asynchronous reset
        @(negedge clk);
        pop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pop = 1'b0;
        chk("busy_before_abort", 32'(ready), 32'(0));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset();
        model_sp = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        v = '{1'b1, 1'b0, 16'h7777, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        apply(v);
        v = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b1};
        apply(v);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
